// File: rtl/ppu_vram_sync_ctrl_if.sv
// Bus bundle between the PPU sync controller, the per-channel
// address PIOs / DMA engines and the VRAM sync writer.
interface ppu_vram_sync_ctrl_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 32
);
  logic                     sync_active;
  logic                     vram_sync;
  logic [NUM_CH-1:0]        vram_sync_mask;
  logic                     vram_sync_done;
  logic [NUM_CH*ADDR_W-1:0] srcaddr_rddata;
  logic [NUM_CH-1:0]        srcaddr_update_avail;
  logic [NUM_CH-1:0]        srcaddr_read_rst;
  logic [NUM_CH*ADDR_W-1:0] dma_src_addr;
  logic [NUM_CH-1:0]        dma_start;
  logic [NUM_CH-1:0]        dma_finish;
  logic                     dma_rdy_irq;

  modport master (
    output sync_active,
    output vram_sync,
    output vram_sync_mask,
    input  vram_sync_done,
    input  srcaddr_rddata,
    input  srcaddr_update_avail,
    output srcaddr_read_rst,
    output dma_src_addr,
    output dma_start,
    input  dma_finish,
    output dma_rdy_irq
  );

  modport slave (
    input  sync_active,
    input  vram_sync,
    input  vram_sync_mask,
    output vram_sync_done,
    output srcaddr_rddata,
    output srcaddr_update_avail,
    input  srcaddr_read_rst,
    input  dma_src_addr,
    input  dma_start,
    output dma_finish,
    input  dma_rdy_irq
  );
endinterface

// File: rtl/ppu_vram_sync_ctrl.sv
// Multi-channel PPU frame controller: arbitrates display, CPU->VRAM
// DMA and vblank VRAM sync across NUM_CH independent regions.
module ppu_vram_sync_ctrl #(
  parameter int NUM_CH   = 3,
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 8,
  parameter int SYNC_ALL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vblank_start,
  input  logic             vblank_end_soon,
  input  logic             rowram_swap,
  output logic             rowram_swap_disp,
  output logic [CNT_W-1:0] frame_skip_cnt,
  output logic             sync_overrun,
  ppu_vram_sync_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISP,
    S_SYNC
  } st_e;

  typedef enum logic [1:0] {
    CH_FREE,
    CH_BUSY,
    CH_READY
  } ch_e;

  localparam logic [CNT_W-1:0] SKIP_MAX = '1;

  st_e st_q, st_d;
  ch_e ch_q [NUM_CH];
  ch_e ch_d [NUM_CH];

  logic [NUM_CH-1:0]        ready_v, busy_v, rd_rst;
  logic [NUM_CH-1:0]        mask_q, mask_d;
  logic [NUM_CH-1:0]        start_q, start_d;
  logic [NUM_CH*ADDR_W-1:0] addr_q, addr_d;
  logic                     sync_q, sync_d;
  logic                     irq_q, irq_d;
  logic                     done_q, done_d;
  logic                     ovr_q, ovr_d;
  logic [CNT_W-1:0]         skip_q, skip_d;
  logic                     done_ev, eligible;

  always_comb begin
    ready_v = '0;
    busy_v  = '0;
    rd_rst  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ready_v[i] = (ch_q[i] == CH_READY);
      busy_v[i]  = (ch_q[i] == CH_BUSY);
      rd_rst[i]  = !rst && (ch_q[i] == CH_FREE)
                   && bus.srcaddr_update_avail[i];
    end
  end

  // Only the first done of a sync window frees channels.
  assign done_ev  = (st_q == S_SYNC) && bus.vram_sync_done
                    && !done_q;
  assign eligible = (|ready_v)
                    && ((SYNC_ALL == 0) || !(|busy_v));

  always_comb begin
    start_d = rd_rst;
    addr_d  = addr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_d[i] = ch_q[i];
      unique case (ch_q[i])
        CH_FREE: begin
          if (bus.srcaddr_update_avail[i]) begin
            ch_d[i] = CH_BUSY;
            addr_d[i*ADDR_W +: ADDR_W] =
              bus.srcaddr_rddata[i*ADDR_W +: ADDR_W];
          end
        end
        CH_BUSY: begin
          if (bus.dma_finish[i]) ch_d[i] = CH_READY;
        end
        CH_READY: begin
          if (done_ev && mask_q[i]) ch_d[i] = CH_FREE;
        end
        default: ch_d[i] = CH_FREE;
      endcase
    end
  end

  always_comb begin
    st_d   = st_q;
    mask_d = mask_q;
    sync_d = 1'b0;
    irq_d  = done_ev;
    done_d = done_q;
    ovr_d  = ovr_q;
    skip_d = skip_q;
    unique case (st_q)
      S_IDLE: begin
        if (vblank_end_soon) st_d = S_DISP;
      end
      S_DISP: begin
        if (vblank_start) begin
          if (eligible) begin
            st_d   = S_SYNC;
            mask_d = ready_v;
            sync_d = 1'b1;
          end else begin
            st_d = S_IDLE;
            if (skip_q != SKIP_MAX)
              skip_d = skip_q + CNT_W'(1);
          end
        end
      end
      S_SYNC: begin
        if (done_ev) begin
          done_d = 1'b1;
          skip_d = '0;
        end
        if (vblank_end_soon) begin
          st_d   = S_DISP;
          done_d = 1'b0;
          mask_d = '0;
          if (!done_q && !bus.vram_sync_done)
            ovr_d = 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= S_IDLE;
      mask_q  <= '0;
      start_q <= '0;
      addr_q  <= '0;
      sync_q  <= 1'b0;
      irq_q   <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      skip_q  <= '0;
      for (int i = 0; i < NUM_CH; i++)
        ch_q[i] <= CH_FREE;
    end else begin
      st_q    <= st_d;
      mask_q  <= mask_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      sync_q  <= sync_d;
      irq_q   <= irq_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      skip_q  <= skip_d;
      for (int i = 0; i < NUM_CH; i++)
        ch_q[i] <= ch_d[i];
    end
  end

  assign rowram_swap_disp     = rowram_swap && (st_q == S_DISP);
  assign bus.sync_active      = (st_q == S_SYNC);
  assign bus.vram_sync        = sync_q;
  assign bus.vram_sync_mask   = mask_q;
  assign bus.srcaddr_read_rst = rd_rst;
  assign bus.dma_src_addr     = addr_q;
  assign bus.dma_start        = start_q;
  assign bus.dma_rdy_irq      = irq_q;
  assign frame_skip_cnt       = skip_q;
  assign sync_overrun         = ovr_q;

endmodule

// File: doc/ppu_vram_sync_ctrl.md
Name: ppu_vram_sync_ctrl

Overview:
Multi-channel successor to the PPU frame FSM. It arbitrates between display, CPU→VRAM DMA and VRAM sync for NUM_CH independent DMA regions (e.g. tiles, patterns, sprites, palettes), each with its own source-address PIO and DMA engine. At vblank it selects which completed regions to copy into PPU-facing VRAM. It also reports dropped frames and sync overruns, which the single-channel design did not do.

Parameters:
NUM_CH, 3, number of DMA channels/VRAM regions (1..8)
ADDR_W, 32, DMA source-address width
CNT_W, 8, frame-skip counter width
SYNC_ALL, 1, 1: sync only when no channel is BUSY; 0: sync any READY channels regardless

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
vblank_start  in  1  1-cycle pulse, display region ended
vblank_end_soon  in  1  1-cycle pulse, display about to resume
rowram_swap  in  1  row-RAM swap request from video out
rowram_swap_disp  out  1  rowram_swap gated to DISP state
sync_active  out  1  high in SYNC; steers VRAM interconnect to sync writer
vram_sync  out  1  1-cycle pulse, start sync writer
vram_sync_mask  out  NUM_CH  channels being synced, stable throughout SYNC
vram_sync_done  in  1  1-cycle pulse from sync writer
srcaddr_rddata  in  NUM_CH*ADDR_W  per-channel PIO address, channel i at [i*ADDR_W +: ADDR_W]
srcaddr_update_avail  in  NUM_CH  per-channel new address available
srcaddr_read_rst  out  NUM_CH  combinational ack, clears update_avail
dma_src_addr  out  NUM_CH*ADDR_W  latched DMA source per channel
dma_start  out  NUM_CH  1-cycle start pulse per channel
dma_finish  in  NUM_CH  1-cycle finish pulse per channel
dma_rdy_irq  out  1  1-cycle pulse, synced channels may accept new DMA
frame_skip_cnt  out  CNT_W  consecutive vblanks without a sync, saturating
sync_overrun  out  1  sticky: a sync was cut off by vblank_end_soon

Behaviour:
- Reset: FSM=IDLE; all channels FREE; all outputs 0 (dma_src_addr=0, mask=0, counters=0). Reset mid-DMA or mid-sync discards all state. No pending start is reissued.
- Channel FSM, per channel i:
  - FREE→BUSY when srcaddr_update_avail[i] is high. In that cycle: srcaddr_read_rst[i]=1 (combinational), and on the same edge dma_src_addr[i] is latched and dma_start[i] is registered high for exactly 1 cycle.
  - BUSY→READY on dma_finish[i].
  - READY→FREE when vram_sync_done arrives in SYNC with mask[i]=1.
  - update_avail outside FREE is ignored: no read_rst. dma_finish outside BUSY is ignored.
- Top FSM:
  - IDLE: vblank_end_soon→DISP. vblank_start is ignored.
  - DISP: on vblank_start, eligible = (any READY) && (SYNC_ALL==0 || no BUSY).
    - If eligible: go to SYNC. mask←READY vector and vram_sync=1 on the same edge (1 cycle). frame_skip_cnt unchanged.
    - Else: go to IDLE and frame_skip_cnt+=1, saturating at 2^CNT_W−1.
  - SYNC: on vram_sync_done, masked channels→FREE, dma_rdy_irq=1 the next cycle, frame_skip_cnt←0, and a done flag is set. On vblank_end_soon: go to DISP. If done is not yet seen, sync_overrun←1 (sticky until rst), masked channels stay READY for retry, and no irq is issued. The done flag and mask clear on the SYNC exit.
- Simultaneous events:
  - done and vblank_end_soon in the same cycle counts as completed: no overrun, transition to DISP.
  - dma_finish[i] on the same cycle as vblank_start does not join that sync; the ready vector is sampled before the update.
  - A second vram_sync_done in the same SYNC is ignored.
- rowram_swap_disp = rowram_swap && state==DISP (combinational).
- sync_active = state==SYNC (combinational).

Test Plan:
- NUM_CH=3, SYNC_ALL=1: write addr 0x1000_0000 on ch0 → read_rst[0] same cycle; next cycle dma_start=001, dma_src_addr[0]=0x1000_0000. finish[0], then vblank_start → vram_sync pulse, mask=001. done → irq 1 cycle later, ch0 accepts a new address.
- SYNC_ALL=1, ch0 READY and ch1 BUSY at vblank_start → IDLE, frame_skip_cnt=1. Repeat 300 vblanks with CNT_W=8 → saturates at 255. Then finish ch1 and vblank → mask=011; done → frame_skip_cnt=0.
- SYNC_ALL=0, same setup → sync with mask=001; ch1 stays BUSY and is unaffected.
- SYNC entered, vblank_end_soon with no done → DISP, sync_overrun=1, no irq, ch0 still READY. Next vblank_start → resync with mask=001.
- Same-cycle done and vblank_end_soon → irq, no overrun. Same-cycle finish[2] and vblank_start → mask bit2=0.
- Assert rst during SYNC with dma_start pending → all outputs 0 immediately. After release, state IDLE and rowram_swap_disp=0 despite rowram_swap=1.
